perceptron_uart_ctrl: RTL and testbench
=======================================

PERCEPTRON_UART_CTRL -- requirements
Module: perceptron_uart_ctrl

Interface
REQ-001 Parameter fp_integer_width, default 2, integer bits of the fixed-point word.
REQ-002 Parameter fp_fract_width, default 10, fraction bits; W = fp_integer_width + fp_fract_width (12).
REQ-003 Parameter n_inputs, default 2, number of perceptron inputs/weights (index range 0..n_inputs-1).
REQ-004 Parameter timeout_cycles, default 120000, maximum clock cycles allowed between bytes of one frame.
REQ-005 Ports, one per line, SHALL be:
 clk  in  1  system clock, all logic on rising edge
 rst_n  in  1  asynchronous active-low reset
 rx_data  in  8  received UART byte
 rx_valid  in  1  one-cycle strobe, rx_data valid
 tx_data  out  8  byte to transmit
 tx_start  out  1  one-cycle request to transmit tx_data
 tx_busy  in  1  transmitter busy
 wr_en  out  1  one-cycle write strobe to perceptron core
 wr_sel  out  2  0 weight, 1 input, 2 bias
 wr_addr  out  8  weight/input index
 wr_data  out  W  fixed-point value
 start  out  1  one-cycle compute request
 done  in  1  one-cycle compute-complete strobe
 result  in  W  signed perceptron output, valid when done=1
 cont_state  out  5  current FSM state code

Function
REQ-006 The block SHALL parse frames from rx bytes: 0x57 'W' idx msb lsb (weight), 0x49 'I' idx msb lsb (input), 0x42 'B' msb lsb (bias), 0x52 'R' (run).
REQ-007 Data words SHALL be assembled as {msb,lsb}; wr_data = low W bits, upper bits discarded.
REQ-008 FSM states and cont_state codes: IDLE=0, GET_IDX=1, GET_MSB=2, GET_LSB=3, WRITE=4, RUN=5, WAIT_DONE=6, TX_MSB=7, TX_LSB=8, TX_ACK=9; cont_state SHALL equal the registered state code.
REQ-009 IDLE: 'W'/'I' -> GET_IDX; 'B' -> GET_MSB; 'R' -> RUN; any other byte -> TX_ACK with code 0x45 'E'.
REQ-010 GET_IDX -> GET_MSB -> GET_LSB, each advanced only by rx_valid; GET_LSB -> WRITE on rx_valid.
REQ-011 WRITE SHALL last one cycle: wr_en=1 with wr_sel/wr_addr/wr_data stable, then TX_ACK with 0x4B 'K'; if idx >= n_inputs, wr_en SHALL stay 0 and ack code SHALL be 0x45.
REQ-012 Bias writes SHALL drive wr_addr=0.
REQ-013 RUN SHALL last one cycle with start=1, then WAIT_DONE.
REQ-014 WAIT_DONE on done=1 SHALL capture result sign-extended to 16 bits, then TX_MSB.
REQ-015 TX_MSB, TX_LSB, TX_ACK: when tx_busy=0, pulse tx_start one cycle with tx_data = byte; then ignore tx_busy for one cycle and advance once tx_busy=0; TX_MSB -> TX_LSB -> IDLE, TX_ACK -> IDLE.
REQ-016 tx_start SHALL never assert while tx_busy=1.
REQ-017 In GET_IDX/GET_MSB/GET_LSB, a byte-gap counter SHALL reset on every rx_valid; on reaching timeout_cycles the FSM SHALL return to IDLE with no write and no transmission.
REQ-018 rx_valid in RUN, WAIT_DONE, WRITE or any TX state SHALL be dropped.
REQ-019 done outside WAIT_DONE SHALL be ignored.
REQ-020 wr_en, start, tx_start SHALL be single-cycle pulses; only one of them asserted per cycle.

Reset
REQ-021 On rst_n=0, asynchronously: state=IDLE, cont_state=0, wr_en=0, start=0, tx_start=0, tx_data=0, wr_sel=0, wr_addr=0, wr_data=0, timeout counter=0, captured result=0.
REQ-022 Reset mid-frame or mid-compute SHALL discard all partial data; after release the FSM SHALL wait for a fresh command byte.

Verification
REQ-023 Bytes 57 01 02 33 -> one cycle wr_en=1, wr_sel=0, wr_addr=1, wr_data=0x233; then tx byte 0x4B.
REQ-024 Bytes 57 05 00 10 (n_inputs=2) -> wr_en never asserted; tx byte 0x45.
REQ-025 Byte 52, core returns done with result=0xC00 (W=12) -> one start pulse; tx bytes 0xFC then 0x00 in order.
REQ-026 Bytes 49 00 then silence > timeout_cycles -> state returns to 0, no wr_en, no tx_start; subsequent 42 01 FF writes bias 0x1FF and acks 0x4B.
REQ-027 tx_busy held high 500 cycles during ack -> tx_start stays 0 until tx_busy falls, then exactly one pulse.
REQ-028 rst_n asserted in WAIT_DONE, late done after release -> no tx_start, cont_state=0.

Source files
------------

// File: rtl/perceptron_uart_ctrl.sv
// UART command parser for a perceptron core: loads weights, inputs and bias
// from byte frames, triggers a compute and returns the result or an ack byte.
module perceptron_uart_ctrl #(
  parameter int fp_integer_width = 2,
  parameter int fp_fract_width   = 10,
  parameter int n_inputs         = 2,
  parameter int timeout_cycles   = 120000
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic [7:0]                                       rx_data,
  input  logic                                             rx_valid,
  output logic [7:0]                                       tx_data,
  output logic                                             tx_start,
  input  logic                                             tx_busy,
  output logic                                             wr_en,
  output logic [1:0]                                       wr_sel,
  output logic [7:0]                                       wr_addr,
  output logic [fp_integer_width+fp_fract_width-1:0]       wr_data,
  output logic                                             start,
  input  logic                                             done,
  input  logic signed [fp_integer_width+fp_fract_width-1:0] result,
  output logic [4:0]                                       cont_state
);
  localparam int W     = fp_integer_width + fp_fract_width;
  localparam int CNT_W = $clog2(timeout_cycles + 1);

  localparam logic [7:0] CMD_WEIGHT = 8'h57;
  localparam logic [7:0] CMD_INPUT  = 8'h49;
  localparam logic [7:0] CMD_BIAS   = 8'h42;
  localparam logic [7:0] CMD_RUN    = 8'h52;
  localparam logic [7:0] ACK_OK     = 8'h4B;
  localparam logic [7:0] ACK_ERR    = 8'h45;

  localparam logic [1:0] PH_SEND = 2'd0;
  localparam logic [1:0] PH_HOLD = 2'd1;
  localparam logic [1:0] PH_WAIT = 2'd2;

  typedef enum logic [4:0] {
    IDLE      = 5'd0,
    GET_IDX   = 5'd1,
    GET_MSB   = 5'd2,
    GET_LSB   = 5'd3,
    WRITE     = 5'd4,
    RUN       = 5'd5,
    WAIT_DONE = 5'd6,
    TX_MSB    = 5'd7,
    TX_LSB    = 5'd8,
    TX_ACK    = 5'd9
  } state_t;

  state_t             state, state_nx;
  logic [1:0]         tx_phase, tx_phase_nx;
  logic [CNT_W-1:0]   gap_cnt;
  logic [7:0]         msb_q;
  logic [7:0]         ack_q;
  logic               idx_ok_q;
  logic signed [15:0] result_q;
  logic               in_get;
  logic               timeout_hit;

  function automatic logic signed [15:0] sext16(input logic signed [W-1:0] v);
    return 16'(v);
  endfunction

  assign cont_state  = state;
  assign in_get      = (state == GET_IDX) || (state == GET_MSB) || (state == GET_LSB);
  assign timeout_hit = in_get && !rx_valid && (gap_cnt == CNT_W'(timeout_cycles - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx_phase <= PH_SEND;
    end else begin
      state    <= state_nx;
      tx_phase <= tx_phase_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    tx_phase_nx = tx_phase;
    wr_en       = 1'b0;
    start       = 1'b0;
    tx_start    = 1'b0;
    tx_data     = 8'h00;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_WEIGHT, CMD_INPUT: state_nx = GET_IDX;
            CMD_BIAS:              state_nx = GET_MSB;
            CMD_RUN:               state_nx = RUN;
            default:               state_nx = TX_ACK;
          endcase
        end
      end
      GET_IDX: if (rx_valid) state_nx = GET_MSB; else if (timeout_hit) state_nx = IDLE;
      GET_MSB: if (rx_valid) state_nx = GET_LSB; else if (timeout_hit) state_nx = IDLE;
      GET_LSB: if (rx_valid) state_nx = WRITE;   else if (timeout_hit) state_nx = IDLE;
      WRITE: begin
        wr_en    = idx_ok_q;
        state_nx = TX_ACK;
      end
      RUN: begin
        start    = 1'b1;
        state_nx = WAIT_DONE;
      end
      WAIT_DONE: if (done) state_nx = TX_MSB;
      TX_MSB, TX_LSB, TX_ACK: begin
        tx_data = (state == TX_MSB) ? result_q[15:8] :
                  (state == TX_LSB) ? result_q[7:0]  : ack_q;
        // The transmitter may only raise busy a cycle after the request, so
        // the cycle following the pulse is not trusted as "idle".
        case (tx_phase)
          PH_SEND: begin
            if (!tx_busy) begin
              tx_start    = 1'b1;
              tx_phase_nx = PH_HOLD;
            end
          end
          PH_HOLD: tx_phase_nx = PH_WAIT;
          default: begin
            if (!tx_busy) begin
              tx_phase_nx = PH_SEND;
              state_nx    = (state == TX_MSB) ? TX_LSB : IDLE;
            end
          end
        endcase
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel   <= 2'd0;
      wr_addr  <= 8'd0;
      wr_data  <= '0;
      msb_q    <= 8'd0;
      ack_q    <= 8'd0;
      idx_ok_q <= 1'b0;
      result_q <= '0;
      gap_cnt  <= '0;
    end else begin
      if (!in_get || rx_valid) gap_cnt <= '0;
      else                     gap_cnt <= gap_cnt + CNT_W'(1);

      case (state)
        IDLE: begin
          if (rx_valid) begin
            case (rx_data)
              CMD_WEIGHT: wr_sel <= 2'd0;
              CMD_INPUT:  wr_sel <= 2'd1;
              CMD_BIAS: begin
                wr_sel   <= 2'd2;
                wr_addr  <= 8'd0;
                idx_ok_q <= 1'b1;
              end
              CMD_RUN: ;
              default: ack_q <= ACK_ERR;
            endcase
          end
        end
        GET_IDX: begin
          if (rx_valid) begin
            wr_addr  <= rx_data;
            idx_ok_q <= (32'(rx_data) < n_inputs);
          end
        end
        GET_MSB: if (rx_valid) msb_q <= rx_data;
        GET_LSB: if (rx_valid) wr_data <= W'({msb_q, rx_data});
        WRITE:   ack_q <= idx_ok_q ? ACK_OK : ACK_ERR;
        WAIT_DONE: if (done) result_q <= sext16(result);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_uart_ctrl.sv
// Directed bench for perceptron_uart_ctrl: table of write frames plus
// hand sequences for run, timeout, busy back-pressure and reset.
module tb_perceptron_uart_ctrl;
  localparam int W   = 12;
  localparam int TMO = 200;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         tx_busy = 1'b0;
  logic         wr_en;
  logic [1:0]   wr_sel;
  logic [7:0]   wr_addr;
  logic [W-1:0] wr_data;
  logic         start;
  logic         done = 1'b0;
  logic [W-1:0] result = '0;
  logic [4:0]   cont_state;

  always #5 clk = ~clk;

  perceptron_uart_ctrl #(
    .fp_integer_width(2),
    .fp_fract_width(10),
    .n_inputs(2),
    .timeout_cycles(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .done(done), .result(result), .cont_state(cont_state)
  );

  int n_checks = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int tx_cnt = 0;
  int start_cnt = 0;
  int viol_cnt = 0;
  logic [1:0]   last_sel = '0;
  logic [7:0]   last_addr = '0;
  logic [W-1:0] last_data = '0;
  logic [7:0]   tx_log[$];
  logic prev_wr = 1'b0, prev_st = 1'b0, prev_tx = 1'b0;

  always @(negedge clk) begin
    if (wr_en) begin
      wr_cnt    <= wr_cnt + 1;
      last_sel  <= wr_sel;
      last_addr <= wr_addr;
      last_data <= wr_data;
    end
    if (tx_start) begin
      tx_log.push_back(tx_data);
      tx_cnt <= tx_cnt + 1;
    end
    if (start) start_cnt <= start_cnt + 1;
    viol_cnt <= viol_cnt
              + int'(tx_start && tx_busy)
              + int'((int'(wr_en) + int'(start) + int'(tx_start)) > 1)
              + int'((wr_en && prev_wr) || (start && prev_st) || (tx_start && prev_tx));
    prev_wr <= wr_en;
    prev_st <= start;
    prev_tx <= tx_start;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int tx_target, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cont_state == 5'd0 && tx_cnt >= tx_target) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    chk({name, " reached idle"}, int'(ok), 1);
  endtask

  // kind 0: wait for tx pulse count, kind 1: wait for start pulse count
  task automatic wait_count(input int kind, input int target, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if ((kind == 0 ? tx_cnt : start_cnt) >= target) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    chk({name, " pulse seen"}, int'(ok), 1);
  endtask

  function automatic int tx_byte(input int k);
    return (tx_log.size() > k) ? int'(tx_log[k]) : -1;
  endfunction

  task automatic run_case(input logic [W-1:0] res, input logic [7:0] e_msb,
                          input logic [7:0] e_lsb, input string name);
    int tx0, st0, wr0;
    tx0 = tx_cnt; st0 = start_cnt; wr0 = wr_cnt;
    send_byte(8'h52);
    wait_count(1, st0 + 1, name);
    tick(3);
    chk({name, " waiting state"}, int'(cont_state), 6);
    send_byte(8'h57);
    tick(2);
    result = res;
    done   = 1'b1;
    tick(1);
    done   = 1'b0;
    wait_idle(tx0 + 2, name);
    tick(5);
    chk({name, " tx count"}, tx_cnt - tx0, 2);
    chk({name, " tx msb"}, tx_byte(tx0), int'(e_msb));
    chk({name, " tx lsb"}, tx_byte(tx0 + 1), int'(e_lsb));
    chk({name, " start count"}, start_cnt - st0, 1);
    chk({name, " no write"}, wr_cnt - wr0, 0);
    chk({name, " final state"}, int'(cont_state), 0);
  endtask

  typedef struct {
    logic [7:0]   cmd;
    logic [7:0]   idx;
    logic [7:0]   msb;
    logic [7:0]   lsb;
    bit           exp_wr;
    logic [1:0]   sel;
    logic [7:0]   addr;
    logic [W-1:0] data;
    logic [7:0]   ack;
  } vec_t;

  vec_t vecs[9];
  int   tx0, wr0, st0;

  initial begin
    vecs[0] = '{8'h57, 8'h01, 8'h02, 8'h33, 1'b1, 2'd0, 8'd1, 12'h233, 8'h4B};
    vecs[1] = '{8'h57, 8'h05, 8'h00, 8'h10, 1'b0, 2'd0, 8'd0, 12'h000, 8'h45};
    vecs[2] = '{8'h49, 8'h00, 8'hFF, 8'hFF, 1'b1, 2'd1, 8'd0, 12'hFFF, 8'h4B};
    vecs[3] = '{8'h49, 8'h01, 8'h12, 8'h34, 1'b1, 2'd1, 8'd1, 12'h234, 8'h4B};
    vecs[4] = '{8'h42, 8'h00, 8'h01, 8'hFF, 1'b1, 2'd2, 8'd0, 12'h1FF, 8'h4B};
    vecs[5] = '{8'h57, 8'h02, 8'h00, 8'h01, 1'b0, 2'd0, 8'd0, 12'h000, 8'h45};
    vecs[6] = '{8'h49, 8'hFF, 8'h00, 8'h00, 1'b0, 2'd0, 8'd0, 12'h000, 8'h45};
    vecs[7] = '{8'h41, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 8'd0, 12'h000, 8'h45};
    vecs[8] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 8'd0, 12'h000, 8'h45};

    tick(3);
    chk("reset cont_state", int'(cont_state), 0);
    chk("reset wr_en", int'(wr_en), 0);
    chk("reset start", int'(start), 0);
    chk("reset tx_start", int'(tx_start), 0);
    chk("reset tx_data", int'(tx_data), 0);
    chk("reset wr_data", int'(wr_data), 0);
    chk("reset wr_addr", int'(wr_addr), 0);
    rst_n = 1'b1;
    tick(2);

    for (int v = 0; v < 9; v++) begin
      tx0 = tx_cnt; wr0 = wr_cnt;
      send_byte(vecs[v].cmd);
      if (vecs[v].cmd == 8'h57 || vecs[v].cmd == 8'h49) send_byte(vecs[v].idx);
      if (vecs[v].cmd == 8'h57 || vecs[v].cmd == 8'h49 || vecs[v].cmd == 8'h42) begin
        send_byte(vecs[v].msb);
        send_byte(vecs[v].lsb);
      end
      wait_idle(tx0 + 1, $sformatf("vec%0d", v));
      tick(3);
      chk($sformatf("vec%0d wr_count", v), wr_cnt - wr0, int'(vecs[v].exp_wr));
      if (vecs[v].exp_wr) begin
        chk($sformatf("vec%0d wr_sel", v), int'(last_sel), int'(vecs[v].sel));
        chk($sformatf("vec%0d wr_addr", v), int'(last_addr), int'(vecs[v].addr));
        chk($sformatf("vec%0d wr_data", v), int'(last_data), int'(vecs[v].data));
      end
      chk($sformatf("vec%0d tx_count", v), tx_cnt - tx0, 1);
      chk($sformatf("vec%0d ack", v), tx_byte(tx0), int'(vecs[v].ack));
    end

    // Compute requests, including an rx byte dropped during WAIT_DONE.
    run_case(12'hC00, 8'hFC, 8'h00, "run neg");
    run_case(12'h123, 8'h01, 8'h23, "run pos");
    run_case(12'h800, 8'hF8, 8'h00, "run min");

    // done outside WAIT_DONE
    tx0 = tx_cnt;
    done = 1'b1; result = 12'h7FF;
    tick(1);
    done = 1'b0;
    tick(10);
    chk("stray done tx", tx_cnt - tx0, 0);
    chk("stray done state", int'(cont_state), 0);

    // Inter-byte timeout, then a bias frame still works.
    tx0 = tx_cnt; wr0 = wr_cnt;
    send_byte(8'h49);
    send_byte(8'h00);
    tick(150);
    chk("timeout early state", int'(cont_state), 2);
    tick(55);
    chk("timeout state", int'(cont_state), 0);
    chk("timeout no write", wr_cnt - wr0, 0);
    chk("timeout no tx", tx_cnt - tx0, 0);
    send_byte(8'h42);
    send_byte(8'h01);
    send_byte(8'hFF);
    wait_idle(tx0 + 1, "post-timeout bias");
    chk("post-timeout wr_count", wr_cnt - wr0, 1);
    chk("post-timeout wr_sel", int'(last_sel), 2);
    chk("post-timeout wr_addr", int'(last_addr), 0);
    chk("post-timeout wr_data", int'(last_data), 12'h1FF);
    chk("post-timeout ack", tx_byte(tx0), 8'h4B);

    // Gaps shorter than the timeout restart the counter each byte.
    tx0 = tx_cnt; wr0 = wr_cnt;
    send_byte(8'h57); tick(150);
    send_byte(8'h00); tick(150);
    send_byte(8'h00); tick(150);
    send_byte(8'h07);
    wait_idle(tx0 + 1, "slow frame");
    chk("slow frame wr_count", wr_cnt - wr0, 1);
    chk("slow frame wr_data", int'(last_data), 7);
    chk("slow frame ack", tx_byte(tx0), 8'h4B);

    // Transmitter busy for a long stretch during the ack.
    tx0 = tx_cnt; wr0 = wr_cnt;
    tx_busy = 1'b1;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
    tick(500);
    chk("busy hold tx", tx_cnt - tx0, 0);
    chk("busy hold state", int'(cont_state), 9);
    chk("busy hold write", wr_cnt - wr0, 1);
    tx_busy = 1'b0;
    wait_idle(tx0 + 1, "busy release");
    tick(3);
    chk("busy release tx", tx_cnt - tx0, 1);
    chk("busy release ack", tx_byte(tx0), 8'h4B);

    // Busy rising right after the pulse must hold the FSM without a resend.
    tx0 = tx_cnt;
    send_byte(8'h58);
    wait_count(0, tx0 + 1, "busy after pulse");
    tx_busy = 1'b1;
    tick(10);
    chk("busy after pulse state", int'(cont_state), 9);
    tx_busy = 1'b0;
    wait_idle(tx0 + 1, "busy after pulse");
    tick(3);
    chk("busy after pulse tx", tx_cnt - tx0, 1);
    chk("busy after pulse ack", tx_byte(tx0), 8'h45);

    // Reset mid-frame discards partial data.
    tx0 = tx_cnt; wr0 = wr_cnt;
    send_byte(8'h49); send_byte(8'h01); send_byte(8'h02);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    send_byte(8'h42); send_byte(8'h00); send_byte(8'h05);
    wait_idle(tx0 + 1, "post-reset bias");
    chk("post-reset wr_count", wr_cnt - wr0, 1);
    chk("post-reset wr_sel", int'(last_sel), 2);
    chk("post-reset wr_data", int'(last_data), 5);

    // Reset during WAIT_DONE, then a late done.
    tx0 = tx_cnt; st0 = start_cnt;
    send_byte(8'h52);
    wait_count(1, st0 + 1, "reset run");
    tick(2);
    rst_n = 1'b0;
    #1;
    chk("async reset state", int'(cont_state), 0);
    chk("async reset wr_data", int'(wr_data), 0);
    chk("async reset wr_sel", int'(wr_sel), 0);
    chk("async reset tx_data", int'(tx_data), 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    result = 12'h155; done = 1'b1;
    tick(1);
    done = 1'b0;
    tick(30);
    chk("late done tx", tx_cnt - tx0, 0);
    chk("late done state", int'(cont_state), 0);
    chk("late done start", start_cnt - st0, 1);

    chk("pulse protocol violations", viol_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
